// File: rtl/tdc_pkg.sv
// Shared constants and types for the TDC hit encoder.
//   CHAIN_LEN_DEF    default taps per carry-chain snapshot
//   BIN_W            bin-count width for the default chain (0..CHAIN_LEN_DEF)
//   TS_W_DEF         default width of the signed interval output
//   BINS_PER_CLK_DEF default calibrated fine bins per clk period
//   FIFO_DEPTH_DEF   default output FIFO depth
//   hit_rec_t        one encoded hit: interval in bins plus {stop_sat, start_sat}
package tdc_pkg;

  localparam int unsigned CHAIN_LEN_DEF    = 32;
  localparam int unsigned BIN_W            = $clog2(CHAIN_LEN_DEF + 1);
  localparam int unsigned TS_W_DEF         = 48;
  localparam int unsigned BINS_PER_CLK_DEF = 32;
  localparam int unsigned FIFO_DEPTH_DEF   = 4;

  // Field is "ts" because "time" is a reserved word.
  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic [1:0]          sat;
  } hit_rec_t;

endpackage

// File: rtl/tdc_hit_encoder_if.sv
// Valid/ready stream carrying encoded hits towards the readout side.
//   out_valid  head entry present
//   out_ready  consumer accepts head when out_valid && out_ready
//   out_time   signed interval in fine bins
//   out_sat    {stop_sat, start_sat}
// master: producer (the encoder). slave: consumer.
interface tdc_hit_encoder_if
  import tdc_pkg::*;
#(
  parameter int unsigned TS_W = TS_W_DEF
);

  logic                   out_valid;
  logic                   out_ready;
  logic signed [TS_W-1:0] out_time;
  logic [1:0]             out_sat;

  modport master (
    output out_valid,
    output out_time,
    output out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_time,
    input  out_sat,
    output out_ready
  );

endinterface

// File: rtl/tdc_thermo_decode.sv
// Thermometer-to-bin-count decoder for one carry-chain snapshot.
// Counts set taps (popcount), so isolated bubbles in the thermometer code do not
// shift the result. Output is registered.
//   clk      system clock
//   rst      asynchronous, active-high reset
//   snap_i   raw CHAIN_LEN-tap snapshot
//   count_o  number of set taps, 0..CHAIN_LEN (registered)
//   sat_o    every tap set (registered)
module tdc_thermo_decode
  import tdc_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHAIN_LEN-1:0] snap_i,
  output logic [CNT_W-1:0]     count_o,
  output logic                 sat_o
);

  logic [CNT_W-1:0] cnt_d;
  logic             sat_d;
  logic [3:0]       nib;
  logic [CNT_W-1:0] count_q;
  logic             sat_q;

  // Sum per-nibble counts; CHAIN_LEN is a multiple of 4 so nibbles tile the chain exactly.
  always_comb begin
    cnt_d = '0;
    nib   = '0;
    for (int unsigned g = 0; g < CHAIN_LEN / 4; g++) begin
      nib   = snap_i[4*g +: 4];
      cnt_d = cnt_d + CNT_W'({2'b00, nib[0]} + {2'b00, nib[1]} +
                             {2'b00, nib[2]} + {2'b00, nib[3]});
    end
    sat_d = (cnt_d == CNT_W'(CHAIN_LEN));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/tdc_hit_encoder.sv
// Carry-chain TDC hit encoder.
// Takes one hit record per in_valid (coarse count plus start->clk and clk->stop snapshots),
// decodes both snapshots to bin counts and forms t = coarse*BINS_PER_CLK + n_start - n_stop.
// Results go through a first-word-fall-through FIFO onto a valid/ready stream.
//   clk            system clock
//   rst            asynchronous, active-high reset
//   in_valid       hit record present (no backpressure; excess hits are dropped)
//   in_coarse      coarse clk-cycle count
//   in_fine_start  raw snapshot, start->clk
//   in_fine_stop   raw snapshot, clk->stop
//   out_if         master side of the result stream
//   drop_count     hits dropped for lack of space, saturating
// Pipeline: S1 input register, S2 decoder registers, S3 interval register, then FIFO.
module tdc_hit_encoder
  import tdc_pkg::*;
#(
  parameter int unsigned CHAIN_LEN    = CHAIN_LEN_DEF,
  parameter int unsigned BINS_PER_CLK = BINS_PER_CLK_DEF,
  parameter int unsigned TS_W         = TS_W_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [31:0]          in_coarse,
  input  logic [CHAIN_LEN-1:0] in_fine_start,
  input  logic [CHAIN_LEN-1:0] in_fine_stop,
  tdc_hit_encoder_if.master    out_if,
  output logic [15:0]          drop_count
);

  localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  // Occupancy can momentarily be compared against FIFO_DEPTH with up to three stages full.
  localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 4);

  // S1: registered inputs
  logic                 s1_valid_q;
  logic [31:0]          s1_coarse_q;
  logic [CHAIN_LEN-1:0] s1_start_q;
  logic [CHAIN_LEN-1:0] s1_stop_q;

  // S2: decoder outputs plus the coarse count travelling alongside
  logic                 s2_valid_q;
  logic [31:0]          s2_coarse_q;
  logic [CNT_W-1:0]     n_start;
  logic [CNT_W-1:0]     n_stop;
  logic                 start_sat;
  logic                 stop_sat;

  // S3: finished interval waiting to enter the FIFO
  logic                 s3_valid_q;
  logic [TS_W-1:0]      s3_time_d;
  logic [TS_W-1:0]      s3_time_q;
  logic [1:0]           s3_sat_q;

  // FIFO
  logic [TS_W-1:0]      mem_time_q [FIFO_DEPTH];
  logic [1:0]           mem_sat_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]    count_q, count_d;
  logic                 push;
  logic                 pop;
  logic                 fifo_valid;

  // Admission
  logic [OCC_W-1:0]     occ;
  logic                 accept;
  logic [15:0]          drop_q, drop_d;

  // Credits: every hit in S1..S3 already owns a FIFO slot, so S3 can always push.
  // occ uses registered state only, so a pop this cycle frees its credit next cycle.
  always_comb begin
    occ    = OCC_W'(count_q) + OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q) + OCC_W'(s3_valid_q);
    accept = in_valid && (occ < OCC_W'(FIFO_DEPTH));
    drop_d = drop_q;
    if (in_valid && !accept && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_coarse_q <= '0;
      s1_start_q  <= '0;
      s1_stop_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_coarse_q <= in_coarse;
        s1_start_q  <= in_fine_start;
        s1_stop_q   <= in_fine_stop;
      end
    end
  end

  tdc_thermo_decode #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_dec_start (
    .clk     (clk),
    .rst     (rst),
    .snap_i  (s1_start_q),
    .count_o (n_start),
    .sat_o   (start_sat)
  );

  tdc_thermo_decode #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_dec_stop (
    .clk     (clk),
    .rst     (rst),
    .snap_i  (s1_stop_q),
    .count_o (n_stop),
    .sat_o   (stop_sat)
  );

  // Arithmetic modulo 2^TS_W gives the same low TS_W bits as zero-extending to TS_W+1
  // and truncating, so negative intervals come out as plain two's complement.
  always_comb begin
    s3_time_d = TS_W'(s2_coarse_q) * TS_W'(BINS_PER_CLK) + TS_W'(n_start) - TS_W'(n_stop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_coarse_q <= '0;
      s3_valid_q  <= 1'b0;
      s3_time_q   <= '0;
      s3_sat_q    <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_coarse_q <= s1_coarse_q;
      end
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_time_q <= s3_time_d;
        s3_sat_q  <= {stop_sat, start_sat};
      end
    end
  end

  assign fifo_valid = (count_q != '0);
  assign push       = s3_valid_q;
  assign pop        = fifo_valid && out_if.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + FCNT_W'(push) - FCNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_time_q[wr_ptr_q] <= s3_time_q;
      mem_sat_q[wr_ptr_q]  <= s3_sat_q;
    end
  end

  // Gate the head so the stream reads zero while empty.
  assign out_if.out_valid = fifo_valid;
  assign out_if.out_time  = fifo_valid ? mem_time_q[rd_ptr_q] : '0;
  assign out_if.out_sat   = fifo_valid ? mem_sat_q[rd_ptr_q] : '0;
  assign drop_count       = drop_q;

endmodule

// File: tb/tb_tdc_hit_encoder.sv
module tb_tdc_hit_encoder;
  import tdc_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned BINS  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_coarse = '0;
  logic [31:0] in_fine_start = '0;
  logic [31:0] in_fine_stop = '0;
  logic [15:0] drop_count;

  int nchecks = 0;
  int nerrors = 0;

  tdc_hit_encoder_if #(.TS_W(TS_W_DEF)) oif ();

  tdc_hit_encoder #(
    .CHAIN_LEN    (32),
    .BINS_PER_CLK (BINS),
    .TS_W         (TS_W_DEF),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_coarse     (in_coarse),
    .in_fine_start (in_fine_start),
    .in_fine_stop  (in_fine_stop),
    .out_if        (oif.master),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] coarse;
    logic [31:0] start;
    logic [31:0] stop;
    logic [47:0] exp_time;
    logic [1:0]  exp_sat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: interval from popcounts, wrapped to 48 bits.
  function automatic logic [47:0] model_time(input logic [31:0] c, input logic [31:0] s,
                                             input logic [31:0] p);
    longint t;
    logic [63:0] u;
    t = longint'({32'h0, c}) * longint'(BINS) + longint'($countones(s))
        - longint'($countones(p));
    u = t;
    return u[47:0];
  endfunction

  function automatic logic [1:0] model_sat(input logic [31:0] s, input logic [31:0] p);
    return {($countones(p) == 32), ($countones(s) == 32)};
  endfunction

  function automatic logic [31:0] rand_snap();
    int n;
    logic [32:0] m;
    case ($urandom_range(0, 2))
      0: return $urandom;
      1: begin
        n = $urandom_range(0, 32);
        m = (33'h1 << n) - 33'h1;
        return m[31:0];
      end
      default: begin
        n = $urandom_range(0, 32);
        m = (33'h1 << n) - 33'h1;
        return m[31:0] ^ (32'h1 << $urandom_range(0, 31));
      end
    endcase
  endfunction

  initial begin
    hit_rec_t    q[$];
    hit_rec_t    head;
    int          acc;
    int          popped;
    int          drops;
    int          budget;
    logic        popped_now;
    logic        prev_stall;
    logic [47:0] prev_time;

    oif.out_ready = 1'b1;

    vecs[0] = '{32'd5,        32'h000000FF, 32'h0000000F, 48'd164,             2'b00};
    vecs[1] = '{32'd5,        32'h000002F7, 32'h0000000F, 48'd164,             2'b00};
    vecs[2] = '{32'd0,        32'h00000003, 32'h000003FF, 48'hFFFF_FFFF_FFF8,  2'b00};
    vecs[3] = '{32'd1,        32'hFFFFFFFF, 32'h00000000, 48'd64,              2'b01};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000000, 48'h001F_FFFF_FFE0,  2'b00};
    vecs[5] = '{32'd0,        32'h00000000, 32'hFFFFFFFF, 48'hFFFF_FFFF_FFE0,  2'b10};
    vecs[6] = '{32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 48'd0,               2'b11};
    vecs[7] = '{32'd2,        32'h0000FFFF, 32'h00000105, 48'd77,              2'b00};

    // Reset state
    repeat (3) tick();
    chk("reset_out_valid", {63'h0, oif.out_valid}, 64'h0);
    chk("reset_out_time", {16'h0, $unsigned(oif.out_time)}, 64'h0);
    chk("reset_out_sat", {62'h0, oif.out_sat}, 64'h0);
    chk("reset_drop_count", {48'h0, drop_count}, 64'h0);
    rst = 1'b0;
    tick();

    // Directed vectors: value, saturation flags and 3-cycle latency
    for (int i = 0; i < 8; i++) begin
      in_valid      = 1'b1;
      in_coarse     = vecs[i].coarse;
      in_fine_start = vecs[i].start;
      in_fine_stop  = vecs[i].stop;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk($sformatf("vec%0d_not_early", i), {63'h0, oif.out_valid}, 64'h0);
      tick();
      chk($sformatf("vec%0d_valid", i), {63'h0, oif.out_valid}, 64'h1);
      chk($sformatf("vec%0d_time", i), {16'h0, $unsigned(oif.out_time)},
          {16'h0, vecs[i].exp_time});
      chk($sformatf("vec%0d_sat", i), {62'h0, oif.out_sat}, {62'h0, vecs[i].exp_sat});
      tick();
      chk($sformatf("vec%0d_drained", i), {63'h0, oif.out_valid}, 64'h0);
      tick();
    end

    // Backpressure: six hits into a stalled output, four fit
    oif.out_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      in_valid      = 1'b1;
      in_coarse     = 32'(c);
      in_fine_start = '0;
      in_fine_stop  = '0;
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("bp_drop_count", {48'h0, drop_count}, 64'd2);
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", {63'h0, oif.out_valid}, 64'h1);
      chk("bp_hold_time", {16'h0, $unsigned(oif.out_time)}, 64'd32);
      tick();
    end
    oif.out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("bp_order%0d_valid", c), {63'h0, oif.out_valid}, 64'h1);
      chk($sformatf("bp_order%0d_time", c), {16'h0, $unsigned(oif.out_time)},
          64'(32 * c));
      tick();
    end
    chk("bp_empty_after", {63'h0, oif.out_valid}, 64'h0);

    // Reset with hits in flight and one buffered
    oif.out_ready = 1'b0;
    for (int c = 7; c <= 9; c++) begin
      in_valid  = 1'b1;
      in_coarse = 32'(c);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("rst_pre_valid", {63'h0, oif.out_valid}, 64'h1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", {63'h0, oif.out_valid}, 64'h0);
    chk("rst_async_time", {16'h0, $unsigned(oif.out_time)}, 64'h0);
    chk("rst_async_drop", {48'h0, drop_count}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    oif.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("rst_no_stale%0d", k), {63'h0, oif.out_valid}, 64'h0);
    end

    // Randomized traffic against the credit/queue model
    acc        = 0;
    popped     = 0;
    drops      = 0;
    prev_stall = 1'b0;
    prev_time  = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_stall) begin
        chk("rnd_stall_valid", {63'h0, oif.out_valid}, 64'h1);
        chk("rnd_stall_time", {16'h0, $unsigned(oif.out_time)}, {16'h0, prev_time});
      end
      in_valid      = ($urandom_range(0, 99) < 60);
      in_coarse     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
      in_fine_start = rand_snap();
      in_fine_stop  = rand_snap();
      oif.out_ready = ($urandom_range(0, 99) < 50);
      popped_now    = 1'b0;
      if (oif.out_valid) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_valid", {63'h0, oif.out_valid}, 64'h0);
        end else if (oif.out_ready) begin
          head = q.pop_front();
          chk("rnd_time", {16'h0, $unsigned(oif.out_time)}, {16'h0, head.ts});
          chk("rnd_sat", {62'h0, oif.out_sat}, {62'h0, head.sat});
          popped_now = 1'b1;
        end
      end
      if (in_valid) begin
        if (acc - popped < int'(DEPTH)) begin
          q.push_back('{ts: model_time(in_coarse, in_fine_start, in_fine_stop),
                        sat: model_sat(in_fine_start, in_fine_stop)});
          acc++;
        end else begin
          drops++;
        end
      end
      if (popped_now) popped++;
      prev_stall = oif.out_valid && !oif.out_ready;
      prev_time  = $unsigned(oif.out_time);
      tick();
    end

    // Drain with a bounded budget
    in_valid      = 1'b0;
    oif.out_ready = 1'b1;
    budget        = 30;
    while (q.size() > 0 && budget > 0) begin
      if (oif.out_valid) begin
        head = q.pop_front();
        chk("drain_time", {16'h0, $unsigned(oif.out_time)}, {16'h0, head.ts});
        chk("drain_sat", {62'h0, oif.out_sat}, {62'h0, head.sat});
      end
      tick();
      budget--;
    end
    chk("drain_leftover", 64'(q.size()), 64'h0);
    chk("drain_out_valid", {63'h0, oif.out_valid}, 64'h0);
    chk("rnd_drop_count", {48'h0, drop_count}, 64'(drops));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
